// File: rtl/frontend_command_definition_pkg.sv
// Shared definitions for the DRAM global controller frontend read path:
// address geometry, write-window size and RAW checker state encoding.
package frontend_command_definition_pkg;

   // Address geometry, packed as {bank, row, col}
   localparam int unsigned BANK_ADDR_BITS = 3;
   localparam int unsigned ROW_ADDR_BITS  = 14;
   localparam int unsigned COL_ADDR_BITS  = 10;
   localparam int unsigned ADDR_WIDTH     = BANK_ADDR_BITS + ROW_ADDR_BITS + COL_ADDR_BITS;

   // Number of pending-write slots exposed by the write address FIFO
   localparam int unsigned WIN_ENTRIES = 8;

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      STALL,
      ISSUE
   } raw_chk_state_t;

   // One write-window slot: MSB is the valid bit, the rest is the address
   typedef logic [ADDR_WIDTH:0] waddr_entry_t;

endpackage

// File: rtl/raw_addr_match.sv
// Combinational valid-qualified comparator of one address against the
// 8-entry pending-write window. Bit k of the mask is set when entry k is
// valid and its full address equals the probe address.
module raw_addr_match
   import frontend_command_definition_pkg::*;
(
   input  logic [WIN_ENTRIES-1:0][ADDR_WIDTH:0] i_win,
   input  logic [ADDR_WIDTH-1:0]                i_addr,
   output logic [WIN_ENTRIES-1:0]               o_match
);

   // Full-width equality gated by each entry's valid bit
   always_comb begin
      o_match = '0;
      for (int k = 0; k < WIN_ENTRIES; k++) begin
         o_match[k] = i_win[k][ADDR_WIDTH] & (i_win[k][ADDR_WIDTH-1:0] == i_addr);
      end
   end

endmodule

// File: rtl/raw_hazard_checker.sv
// Read-after-write hazard checker. Holds one frontend read, compares it with
// the pending-write window and stalls it (while freezing write pushes) until
// every matching write has drained, then releases it with valid/ready.
module raw_hazard_checker
   import frontend_command_definition_pkg::*;
#(
   parameter int unsigned MAX_STALL = 255
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_rd_valid,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic                  o_rd_ready,
   input  logic [ADDR_WIDTH:0]   i_waddr_0,
   input  logic [ADDR_WIDTH:0]   i_waddr_1,
   input  logic [ADDR_WIDTH:0]   i_waddr_2,
   input  logic [ADDR_WIDTH:0]   i_waddr_3,
   input  logic [ADDR_WIDTH:0]   i_waddr_4,
   input  logic [ADDR_WIDTH:0]   i_waddr_5,
   input  logic [ADDR_WIDTH:0]   i_waddr_6,
   input  logic [ADDR_WIDTH:0]   i_waddr_7,
   output logic                  o_wr_hold,
   output logic                  o_rd_valid,
   output logic [ADDR_WIDTH-1:0] o_rd_addr,
   input  logic                  i_rd_ready,
   output logic [7:0]            o_hazard_mask,
   output logic                  o_hazard,
   output logic                  o_stall_timeout
);

   localparam int unsigned CntW = $clog2(MAX_STALL + 1);
   localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_STALL);

   raw_chk_state_t                 state_q;
   logic [ADDR_WIDTH-1:0]          hold_addr_q;
   logic [CntW-1:0]                stall_cnt_q;
   logic [WIN_ENTRIES-1:0][ADDR_WIDTH:0] win;
   logic [WIN_ENTRIES-1:0]         match;

   assign win[0] = i_waddr_0;
   assign win[1] = i_waddr_1;
   assign win[2] = i_waddr_2;
   assign win[3] = i_waddr_3;
   assign win[4] = i_waddr_4;
   assign win[5] = i_waddr_5;
   assign win[6] = i_waddr_6;
   assign win[7] = i_waddr_7;

   raw_addr_match u_match (
      .i_win   (win),
      .i_addr  (hold_addr_q),
      .o_match (match)
   );

   // Checker FSM with all handshake and status outputs registered
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q         <= IDLE;
         hold_addr_q     <= '0;
         stall_cnt_q     <= '0;
         o_rd_ready      <= 1'b1;
         o_rd_valid      <= 1'b0;
         o_rd_addr       <= '0;
         o_wr_hold       <= 1'b0;
         o_hazard        <= 1'b0;
         o_hazard_mask   <= '0;
         o_stall_timeout <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (i_rd_valid) begin
                  hold_addr_q <= i_rd_addr;
                  o_rd_ready  <= 1'b0;
                  state_q     <= CHECK;
               end
            end
            CHECK: begin
               o_hazard_mask <= match;
               if (match == '0) begin
                  o_rd_valid <= 1'b1;
                  o_rd_addr  <= hold_addr_q;
                  state_q    <= ISSUE;
               end else begin
                  // Freeze the window so draining writes are the only change
                  stall_cnt_q <= '0;
                  o_wr_hold   <= 1'b1;
                  o_hazard    <= 1'b1;
                  state_q     <= STALL;
               end
            end
            STALL: begin
               if (match == '0) begin
                  o_hazard_mask <= '0;
                  o_wr_hold     <= 1'b0;
                  o_hazard      <= 1'b0;
                  o_rd_valid    <= 1'b1;
                  o_rd_addr     <= hold_addr_q;
                  state_q       <= ISSUE;
               end else begin
                  o_hazard_mask <= match;
                  // Saturating count; timeout only flags, never force-issues
                  if (stall_cnt_q != MaxCnt) begin
                     stall_cnt_q <= stall_cnt_q + 1'b1;
                     if (stall_cnt_q == MaxCnt - 1'b1) begin
                        o_stall_timeout <= 1'b1;
                     end
                  end
               end
            end
            ISSUE: begin
               // Younger writes arriving now cannot hazard this read
               if (i_rd_ready) begin
                  o_rd_valid <= 1'b0;
                  o_rd_ready <= 1'b1;
                  state_q    <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_raw_hazard_checker.sv
// Directed self-checking bench for raw_hazard_checker (MAX_STALL = 4).
module tb_raw_hazard_checker;
   import frontend_command_definition_pkg::*;

   logic                  clk;
   logic                  rst;
   logic                  rd_valid_in;
   logic [ADDR_WIDTH-1:0] rd_addr_in;
   logic                  rd_ready_out;
   logic [ADDR_WIDTH:0]   win [8];
   logic                  wr_hold;
   logic                  rd_valid_out;
   logic [ADDR_WIDTH-1:0] rd_addr_out;
   logic                  rd_ready_in;
   logic [7:0]            hazard_mask;
   logic                  hazard;
   logic                  stall_timeout;

   int total;
   int bad;

   raw_hazard_checker #(
      .MAX_STALL (4)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_rd_valid      (rd_valid_in),
      .i_rd_addr       (rd_addr_in),
      .o_rd_ready      (rd_ready_out),
      .i_waddr_0       (win[0]),
      .i_waddr_1       (win[1]),
      .i_waddr_2       (win[2]),
      .i_waddr_3       (win[3]),
      .i_waddr_4       (win[4]),
      .i_waddr_5       (win[5]),
      .i_waddr_6       (win[6]),
      .i_waddr_7       (win[7]),
      .o_wr_hold       (wr_hold),
      .o_rd_valid      (rd_valid_out),
      .o_rd_addr       (rd_addr_out),
      .i_rd_ready      (rd_ready_in),
      .o_hazard_mask   (hazard_mask),
      .o_hazard        (hazard),
      .o_stall_timeout (stall_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs are driven and outputs sampled 1ns after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_win();
      for (int k = 0; k < 8; k++) win[k] = '0;
   endtask

   // Present a read for one edge; afterwards the DUT is in CHECK
   task automatic send_read(input logic [ADDR_WIDTH-1:0] a);
      rd_valid_in = 1'b1;
      rd_addr_in  = a;
      tick();
      rd_valid_in = 1'b0;
   endtask

   task automatic handshake();
      rd_ready_in = 1'b1;
      tick();
      rd_ready_in = 1'b0;
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      rst         = 1'b1;
      rd_valid_in = 1'b0;
      rd_addr_in  = '0;
      rd_ready_in = 1'b0;
      clear_win();
      tick();
      tick();
      check_eq("rst_rd_ready", 32'(rd_ready_out), 32'd1);
      check_eq("rst_rd_valid", 32'(rd_valid_out), 32'd0);
      check_eq("rst_wr_hold", 32'(wr_hold), 32'd0);
      check_eq("rst_hazard", 32'(hazard), 32'd0);
      check_eq("rst_mask", 32'(hazard_mask), 32'h00);
      check_eq("rst_timeout", 32'(stall_timeout), 32'd0);
      rst = 1'b0;
      tick();

      // No hazard: empty window, issue two edges after acceptance
      send_read(ADDR_WIDTH'(32'h12345));
      check_eq("nh_check_ready", 32'(rd_ready_out), 32'd0);
      check_eq("nh_check_valid", 32'(rd_valid_out), 32'd0);
      tick();
      check_eq("nh_valid", 32'(rd_valid_out), 32'd1);
      check_eq("nh_addr", 32'(rd_addr_out), 32'h12345);
      check_eq("nh_mask", 32'(hazard_mask), 32'h00);
      check_eq("nh_wr_hold", 32'(wr_hold), 32'd0);
      handshake();
      check_eq("nh_done_valid", 32'(rd_valid_out), 32'd0);
      check_eq("nh_done_ready", 32'(rd_ready_out), 32'd1);

      // Single hit in entry 3
      win[3] = {1'b1, ADDR_WIDTH'(32'h00ABC)};
      send_read(ADDR_WIDTH'(32'h00ABC));
      tick();
      check_eq("sh_mask", 32'(hazard_mask), 32'h08);
      check_eq("sh_wr_hold", 32'(wr_hold), 32'd1);
      check_eq("sh_hazard", 32'(hazard), 32'd1);
      check_eq("sh_valid_stall", 32'(rd_valid_out), 32'd0);
      tick();
      check_eq("sh_still_stall", 32'(hazard), 32'd1);
      win[3][ADDR_WIDTH] = 1'b0;
      tick();
      check_eq("sh_valid", 32'(rd_valid_out), 32'd1);
      check_eq("sh_addr", 32'(rd_addr_out), 32'h00ABC);
      check_eq("sh_hazard_off", 32'(hazard), 32'd0);
      check_eq("sh_wr_hold_off", 32'(wr_hold), 32'd0);
      check_eq("sh_mask_clr", 32'(hazard_mask), 32'h00);
      handshake();
      clear_win();

      // Multiple hits in entries 0 and 5, drained one at a time
      win[0] = {1'b1, ADDR_WIDTH'(32'h00ABC)};
      win[5] = {1'b1, ADDR_WIDTH'(32'h00ABC)};
      win[6] = {1'b1, ADDR_WIDTH'(32'h00ABD)};
      send_read(ADDR_WIDTH'(32'h00ABC));
      tick();
      check_eq("mh_mask_21", 32'(hazard_mask), 32'h21);
      win[0][ADDR_WIDTH] = 1'b0;
      tick();
      check_eq("mh_mask_20", 32'(hazard_mask), 32'h20);
      check_eq("mh_hazard", 32'(hazard), 32'd1);
      check_eq("mh_valid_low", 32'(rd_valid_out), 32'd0);
      win[5][ADDR_WIDTH] = 1'b0;
      tick();
      check_eq("mh_valid", 32'(rd_valid_out), 32'd1);
      check_eq("mh_timeout", 32'(stall_timeout), 32'd0);
      // Backpressure: output held stable for three cycles
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("bp_valid", 32'(rd_valid_out), 32'd1);
         check_eq("bp_addr", 32'(rd_addr_out), 32'h00ABC);
      end
      handshake();
      check_eq("bp_done", 32'(rd_valid_out), 32'd0);
      clear_win();

      // Invalid entry with equal address never matches
      win[2] = {1'b0, ADDR_WIDTH'(32'h00ABC)};
      send_read(ADDR_WIDTH'(32'h00ABC));
      tick();
      check_eq("inv_valid", 32'(rd_valid_out), 32'd1);
      check_eq("inv_mask", 32'(hazard_mask), 32'h00);
      check_eq("inv_wr_hold", 32'(wr_hold), 32'd0);
      // A new read outside IDLE is ignored
      rd_valid_in = 1'b1;
      rd_addr_in  = ADDR_WIDTH'(32'h00055);
      tick();
      check_eq("ign_ready", 32'(rd_ready_out), 32'd0);
      check_eq("ign_addr", 32'(rd_addr_out), 32'h00ABC);
      rd_valid_in = 1'b0;
      handshake();
      clear_win();

      // Timeout after four stall cycles; flag is sticky across the issue
      win[1] = {1'b1, ADDR_WIDTH'(32'h00777)};
      send_read(ADDR_WIDTH'(32'h00777));
      tick();
      check_eq("to_stall0", 32'(stall_timeout), 32'd0);
      tick();
      tick();
      tick();
      check_eq("to_stall3", 32'(stall_timeout), 32'd0);
      tick();
      check_eq("to_set", 32'(stall_timeout), 32'd1);
      tick();
      tick();
      check_eq("to_no_force", 32'(rd_valid_out), 32'd0);
      check_eq("to_hazard", 32'(hazard), 32'd1);
      check_eq("to_mask", 32'(hazard_mask), 32'h02);
      win[1][ADDR_WIDTH] = 1'b0;
      tick();
      check_eq("to_issue", 32'(rd_valid_out), 32'd1);
      check_eq("to_issue_addr", 32'(rd_addr_out), 32'h00777);
      handshake();
      check_eq("to_sticky", 32'(stall_timeout), 32'd1);
      clear_win();

      // Reset during STALL
      win[4] = {1'b1, ADDR_WIDTH'(32'h00999)};
      send_read(ADDR_WIDTH'(32'h00999));
      tick();
      check_eq("rs_in_stall", 32'(hazard), 32'd1);
      rst = 1'b1;
      tick();
      check_eq("rs_ready", 32'(rd_ready_out), 32'd1);
      check_eq("rs_valid", 32'(rd_valid_out), 32'd0);
      check_eq("rs_addr", 32'(rd_addr_out), 32'h0);
      check_eq("rs_hazard", 32'(hazard), 32'd0);
      check_eq("rs_wr_hold", 32'(wr_hold), 32'd0);
      check_eq("rs_mask", 32'(hazard_mask), 32'h00);
      check_eq("rs_timeout", 32'(stall_timeout), 32'd0);
      rst = 1'b0;
      clear_win();
      tick();
      check_eq("rs_idle_ready", 32'(rd_ready_out), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/raw_hazard_checker.md
Name: raw_hazard_checker

Overview:
- Sits directly downstream of the write address FIFO in the DRAM global controller read path.
- Accepts one frontend read request at a time and compares its {bank, row, col} address against the FIFO's 8-entry window of pending writes (each with a valid bit).
- A hit stalls the read until every matching write has drained. It also holds off new write pushes during the stall so the window stays stable.
- Releases the read to the scheduler with a valid/ready handshake.

Parameters:
- ADDR_WIDTH, `ROW_ADDR_BITS+`COL_ADDR_BITS+`BANK_ADDR_BITS: read/write address width, {bank,row,col}.
- WIN_ENTRIES, 8: number of write-window entries compared; fixed at 8.
- MAX_STALL, 255: stall cycles before the sticky timeout flag sets.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_rd_valid  in  1  frontend read request valid
- i_rd_addr  in  ADDR_WIDTH  frontend read address
- o_rd_ready  out  1  checker can accept a read
- i_waddr_0..i_waddr_7  in  ADDR_WIDTH+1 each  write window; MSB is valid; entry 0 oldest
- o_wr_hold  out  1  upstream must not push the write FIFO while high
- o_rd_valid  out  1  read released to scheduler
- o_rd_addr  out  ADDR_WIDTH  released read address
- i_rd_ready  in  1  scheduler accepts read
- o_hazard_mask  out  8  registered per-entry match mask, bit k = entry k
- o_hazard  out  1  high while in STALL
- o_stall_timeout  out  1  sticky: stall reached MAX_STALL cycles

Behaviour:
- One clock (i_clk). Synchronous active-high reset (i_rst).
- Reset (also mid-operation):
  - state=IDLE; held address discarded.
  - Counter=0; o_hazard_mask=0; o_stall_timeout=0.
  - o_rd_valid=0, o_rd_addr=0, o_wr_hold=0, o_hazard=0, o_rd_ready=1 in the cycle after reset.
- Match function (combinational):
  - match[k] = i_waddr_k[ADDR_WIDTH] & (i_waddr_k[ADDR_WIDTH-1:0] == hold_addr).
  - Full-width equality only; an invalid entry never matches.
- States:
  - IDLE: o_rd_ready=1. On i_rd_valid: latch i_rd_addr into hold_addr, go to CHECK.
  - CHECK: o_rd_ready=0; o_hazard_mask<=match.
    - match==0: go to ISSUE.
    - Otherwise: go to STALL and clear the counter.
  - STALL: o_wr_hold=1, o_hazard=1. Each cycle o_hazard_mask<=match.
    - match==0: go to ISSUE, with mask cleared.
    - Counter increments, saturating at MAX_STALL. On reaching MAX_STALL, o_stall_timeout<=1 (sticky until reset). The read is never force-issued.
  - ISSUE: o_rd_valid=1, o_rd_addr=hold_addr.
    - Both stay stable while i_rd_ready=0.
    - On i_rd_valid_out & i_rd_ready: o_rd_valid<=0, go to IDLE.
    - Writes are not rechecked in ISSUE; any later write is younger than the read.
- Latency:
  - Read accepted at edge T, no hazard: o_rd_valid high from T+2.
  - Hit: o_rd_valid high one cycle after the edge where the last matching valid bit clears.
- Throughput: at most one read per 3 cycles (IDLE→CHECK→ISSUE).
- o_wr_hold asserts the cycle after CHECK detects a hit.
  - A push arriving in the CHECK cycle itself is allowed; it is younger and is ignored by the exit condition only if it clears, so upstream treats o_wr_hold as a registered stall.
- Counter width is $clog2(MAX_STALL+1); no wrap.
- Simultaneous events:
  - A matching entry clearing in the same cycle as CHECK is seen as cleared only if its valid bit is already 0 at that edge.
  - i_rd_valid outside IDLE is ignored; o_rd_ready=0.

Decomposition:
- Shared package (frontend_command_definition_pkg):
  - ADDR_WIDTH localparam and WIN_ENTRIES=8.
  - typedef enum logic [1:0] raw_chk_state_t {IDLE, CHECK, STALL, ISSUE}.
  - typedef logic [ADDR_WIDTH:0] waddr_entry_t.
- One sub-module: raw_addr_match, a combinational 8-way valid-qualified comparator producing the 8-bit mask, reusable by the scheduler.

Test Plan:
- No hazard: all window entries valid=0; read 0x12345 accepted at T → o_rd_valid=1 at T+2, o_rd_addr=0x12345, o_hazard_mask=0, o_wr_hold never 1.
- Single hit: i_waddr_3={1,0x00ABC}; read 0x00ABC → STALL, o_hazard_mask=8'h08, o_wr_hold=1; clear entry 3 valid at edge S → o_rd_valid=1 at S+1.
- Multiple hits: entries 0 and 5 = {1,0x00ABC} → mask 8'h21; clear entry 0 → mask 8'h20, still STALL; clear entry 5 → ISSUE next cycle.
- Invalid-entry match: i_waddr_2={0,0x00ABC}, read 0x00ABC → no stall, o_rd_valid at T+2.
- Timeout: MAX_STALL=4, hit held → o_stall_timeout=1 after 4 STALL cycles, state stays STALL; clear the hit → read issues and o_stall_timeout stays 1 until i_rst.
- Backpressure/reset: i_rd_ready=0 for 3 ISSUE cycles → o_rd_valid and o_rd_addr stable. i_rst=1 during STALL → next cycle IDLE, o_rd_ready=1, all other outputs 0.
